// File: rtl/micro_op_packer_pkg.sv
// ----------------------------------------------------------------------------
// micro_op_packer_pkg
//   Shared width helpers and default parameter values for the micro-op
//   packer. The packer and its compactor are parametrised, so the field
//   widths are derived from these functions. The entry record itself is
//   declared inside the packer, where its field widths are known.
//
//   Derived widths:
//     mop_count_bits(MOP_MAX) : width of one lane of in_count (0..MOP_MAX)
//     mop_index_bits(MOP_MAX) : width of a micro-op index (0..MOP_MAX-1),
//                               at least 1 bit
//     ptr_bits(DEPTH)         : width of the head/tail pointers
// ----------------------------------------------------------------------------
package micro_op_packer_pkg;

  localparam int unsigned DEF_IN_WIDTH  = 2;
  localparam int unsigned DEF_MOP_MAX   = 3;
  localparam int unsigned DEF_OUT_WIDTH = 2;
  localparam int unsigned DEF_DEPTH     = 8;
  localparam int unsigned DEF_PAYLOAD_W = 64;
  localparam int unsigned DEF_SID_W     = 10;

  function automatic int unsigned mop_count_bits(input int unsigned mop_max);
    return $clog2(mop_max + 1);
  endfunction

  // A single-op instruction still needs a 1-bit index field.
  function automatic int unsigned mop_index_bits(input int unsigned mop_max);
    return (mop_max > 1) ? $clog2(mop_max) : 1;
  endfunction

  function automatic int unsigned ptr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/micro_op_compactor.sv
// ----------------------------------------------------------------------------
// micro_op_compactor
//   Purely combinational. Takes the per-lane micro-op counts of one decode
//   group and works out where each of the IN_WIDTH*MOP_MAX input slots lands
//   in the buffer. The offsets are relative to the tail pointer. Empty lanes
//   leave no gap. Counts above MOP_MAX are clamped.
//
//   Ports:
//     in_count   : per-lane micro-op count, lane 0 in the low bits
//     slot_we    : slot s = k*MOP_MAX + j carries a valid micro-op
//     slot_off   : write offset of slot s from the tail
//     slot_mid   : index j of the micro-op within its instruction
//     slot_last  : slot s is the final micro-op of its instruction
//     push_total : total micro-ops in the group (after clamping)
//     count_over : some lane requested more than MOP_MAX micro-ops
// ----------------------------------------------------------------------------
module micro_op_compactor
  import micro_op_packer_pkg::*;
#(
  parameter  int unsigned IN_WIDTH = DEF_IN_WIDTH,
  parameter  int unsigned MOP_MAX  = DEF_MOP_MAX,
  parameter  int unsigned PTR_W    = ptr_bits(DEF_DEPTH),
  localparam int unsigned CB       = mop_count_bits(MOP_MAX),
  localparam int unsigned MB       = mop_index_bits(MOP_MAX),
  localparam int unsigned NS       = IN_WIDTH * MOP_MAX,
  localparam int unsigned SB       = $clog2(NS + 1)
) (
  input  logic [IN_WIDTH*CB-1:0] in_count,
  output logic [NS-1:0]          slot_we,
  output logic [NS*PTR_W-1:0]    slot_off,
  output logic [NS*MB-1:0]       slot_mid,
  output logic [NS-1:0]          slot_last,
  output logic [SB-1:0]          push_total,
  output logic                   count_over
);

  int raw_cnt;
  int lane_cnt;
  int base;

  always_comb begin
    // NOTE: every variable driven here gets a default before the loops, so
    // no path through the block leaves a value held (no latch).
    slot_we    = '0;
    slot_off   = '0;
    slot_mid   = '0;
    slot_last  = '0;
    count_over = 1'b0;
    raw_cnt    = 0;
    lane_cnt   = 0;
    base       = 0;
    for (int k = 0; k < int'(IN_WIDTH); k++) begin
      raw_cnt = int'(in_count[k*CB +: CB]);
      if (raw_cnt > int'(MOP_MAX)) begin
        count_over = 1'b1;
        lane_cnt   = int'(MOP_MAX);
      end else begin
        lane_cnt   = raw_cnt;
      end
      for (int j = 0; j < int'(MOP_MAX); j++) begin
        if (j < lane_cnt) begin
          slot_we[k*MOP_MAX + j]                 = 1'b1;
          slot_off[(k*MOP_MAX + j)*PTR_W +: PTR_W] = PTR_W'(base + j);
          slot_mid[(k*MOP_MAX + j)*MB +: MB]       = MB'(j);
          slot_last[k*MOP_MAX + j]               = (j == lane_cnt - 1);
        end
      end
      // Running prefix sum: the next lane starts right after this one.
      base = base + lane_cnt;
    end
    push_total = SB'(base);
  end

endmodule

// File: rtl/micro_op_packer.sv
// ----------------------------------------------------------------------------
// micro_op_packer
//   Micro-op expansion buffer between decode and rename. Each cycle it
//   accepts up to IN_WIDTH instructions of 0..MOP_MAX micro-ops, compacts
//   them in program order into a DEPTH-entry circular buffer, and presents
//   up to OUT_WIDTH micro-ops combinationally from the head. Each micro-op
//   is tagged with its serial id, its index in the instruction and a last
//   flag. An instruction may straddle output cycles.
//
//   Ports:
//     clk, rst     : clock; synchronous active-high reset
//     flush        : drop all buffered and same-cycle incoming micro-ops
//     in_valid     : decode group valid
//     in_ready     : room for a worst-case group (registered occupancy only)
//     in_count     : micro-op count per lane, lane 0 in the low bits
//     in_mop       : payloads, lane-major, micro-op index minor
//     in_sid       : serial id per lane
//     out_valid    : lane i holds a micro-op (i < occupancy)
//     out_mop/sid/mid/last : lane i shows entry head+i
//     out_take     : number of leading lanes consumed this cycle
//     stat_stall   : cycles with in_valid && !in_ready && !flush
//     stat_issued  : micro-ops consumed
//
//   Build option: define MICRO_OP_PACKER_STAT_EN to get saturating 32-bit
//   stat counters. Without it, both stat ports are tied to 0.
// ----------------------------------------------------------------------------
module micro_op_packer
  import micro_op_packer_pkg::*;
#(
  parameter  int unsigned IN_WIDTH  = DEF_IN_WIDTH,
  parameter  int unsigned MOP_MAX   = DEF_MOP_MAX,
  parameter  int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
  parameter  int unsigned DEPTH     = DEF_DEPTH,
  parameter  int unsigned PAYLOAD_W = DEF_PAYLOAD_W,
  parameter  int unsigned SID_W     = DEF_SID_W,
  localparam int unsigned CB        = mop_count_bits(MOP_MAX),
  localparam int unsigned MB        = mop_index_bits(MOP_MAX),
  localparam int unsigned TB        = $clog2(OUT_WIDTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [IN_WIDTH*CB-1:0]          in_count,
  input  logic [IN_WIDTH*MOP_MAX*PAYLOAD_W-1:0] in_mop,
  input  logic [IN_WIDTH*SID_W-1:0]       in_sid,
  output logic [OUT_WIDTH-1:0]            out_valid,
  output logic [OUT_WIDTH*PAYLOAD_W-1:0]  out_mop,
  output logic [OUT_WIDTH*SID_W-1:0]      out_sid,
  output logic [OUT_WIDTH*MB-1:0]         out_mid,
  output logic [OUT_WIDTH-1:0]            out_last,
  input  logic [TB-1:0]                   out_take,
  output logic [31:0]                     stat_stall,
  output logic [31:0]                     stat_issued
);

  localparam int unsigned PB = ptr_bits(DEPTH);
  localparam int unsigned CW = PB + 1;               // occupancy 0..DEPTH
  localparam int unsigned NS = IN_WIDTH * MOP_MAX;
  localparam int unsigned SB = $clog2(NS + 1);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [SID_W-1:0]     sid;
    logic [MB-1:0]        mid;
    logic                 last;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PB-1:0] head_q, head_d;
  logic [PB-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;

  logic [NS-1:0]    slot_we;
  logic [NS*PB-1:0] slot_off;
  logic [NS*MB-1:0] slot_mid;
  logic [NS-1:0]    slot_last;
  logic [SB-1:0]    push_total;
  logic             count_over;

  logic          push;
  logic [CW-1:0] push_n;
  logic [CW-1:0] pop_n;
  logic [TB-1:0] avail_t;
  logic [TB-1:0] pop_t;
  logic [PB-1:0] wr_idx;
  logic [PB-1:0] rd_idx;

  micro_op_compactor #(
    .IN_WIDTH (IN_WIDTH),
    .MOP_MAX  (MOP_MAX),
    .PTR_W    (PB)
  ) u_compactor (
    .in_count   (in_count),
    .slot_we    (slot_we),
    .slot_off   (slot_off),
    .slot_mid   (slot_mid),
    .slot_last  (slot_last),
    .push_total (push_total),
    .count_over (count_over)
  );

  // ---------------------------------------------------------------- control
  always_comb begin
    // Lanes that may be popped: min(occupancy, OUT_WIDTH). An oversized
    // out_take is clamped to this.
    avail_t = (cnt_q < CW'(OUT_WIDTH)) ? TB'(cnt_q) : TB'(OUT_WIDTH);
    pop_t   = (out_take > avail_t) ? avail_t : out_take;

    push   = in_valid && in_ready_q && !flush;
    push_n = push ? CW'(push_total) : '0;
    pop_n  = flush ? '0 : CW'(pop_t);

    head_d = head_q + PB'(pop_n);
    tail_d = tail_q + PB'(push_n);
    cnt_d  = cnt_q + push_n - pop_n;

    mem_d  = mem_q;
    wr_idx = '0;
    for (int s = 0; s < int'(NS); s++) begin
      if (push && slot_we[s]) begin
        wr_idx = tail_q + slot_off[s*PB +: PB];
        mem_d[wr_idx] = '{
          payload: in_mop[s*PAYLOAD_W +: PAYLOAD_W],
          sid:     in_sid[(s / MOP_MAX)*SID_W +: SID_W],
          mid:     slot_mid[s*MB +: MB],
          last:    slot_last[s]
        };
      end
    end

    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end

    // Registered so in_ready depends on occupancy alone, never on the
    // same-cycle pop; it equals the room check on the current cnt_q.
    in_ready_d = (cnt_d <= CW'(DEPTH - NS));
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  // NOTE: the entry storage is deliberately not reset. cnt_q qualifies
  // every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready = in_ready_q;

  // ---------------------------------------------------------------- output
  always_comb begin
    out_valid = '0;
    out_mop   = '0;
    out_sid   = '0;
    out_mid   = '0;
    out_last  = '0;
    rd_idx    = '0;
    for (int i = 0; i < int'(OUT_WIDTH); i++) begin
      rd_idx = head_q + PB'(i);
      out_valid[i]                         = (CW'(i) < cnt_q);
      out_mop[i*PAYLOAD_W +: PAYLOAD_W]    = mem_q[rd_idx].payload;
      out_sid[i*SID_W +: SID_W]            = mem_q[rd_idx].sid;
      out_mid[i*MB +: MB]                  = mem_q[rd_idx].mid;
      out_last[i]                          = mem_q[rd_idx].last;
    end
  end

  // ------------------------------------------------------------ assertions
  a_take_legal : assert property (@(posedge clk) disable iff (rst || flush)
    out_take <= avail_t);

  a_count_legal : assert property (@(posedge clk) disable iff (rst || flush)
    !(in_valid && count_over));

  // ----------------------------------------------------------------- stats
`ifdef MICRO_OP_PACKER_STAT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] issued_q, issued_d;
  logic [32:0] issued_sum;

  always_comb begin
    stall_d    = stall_q;
    issued_sum = {1'b0, issued_q} + 33'(pop_n);
    if (in_valid && !in_ready_q && !flush && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
    issued_d = issued_sum[32] ? '1 : issued_sum[31:0];
  end

  // Stats survive flush; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      issued_q <= '0;
    end else begin
      stall_q  <= stall_d;
      issued_q <= issued_d;
    end
  end

  assign stat_stall  = stall_q;
  assign stat_issued = issued_q;
`else
  assign stat_stall  = '0;
  assign stat_issued = '0;
`endif

endmodule
